abs_diff_err_monitor: RTL

Self-checking evaluation stage wrapped around one approximate absolute-difference netlist from the synthesis flow. It sweeps every input vector into the netlist's `in*` pins and consumes its `out*` pins. It compares each result against an internal exact model and accumulates the error statistics needed to confirm the netlist meets its error threshold (ET). It is instantiated once per candidate circuit in the on-FPGA/emulation evaluation harness.

---
 rtl/abs_diff_eval_pkg.sv | 20 ++
 rtl/abs_diff_exact_ref.sv | 19 +
 rtl/abs_diff_err_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/abs_diff_eval_pkg.sv
// Shared types and arithmetic helpers for the absolute-difference evaluation harness.
package abs_diff_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } eval_state_e;

  // Helpers are 32 bits wide; callers narrow the result to their own widths.
  function automatic logic [31:0] abs_sub(input logic [31:0] x, input logic [31:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [31:0] exact_abs_diff(input logic [31:0] a, input logic [31:0] b);
    return abs_sub(a, b);
  endfunction

endpackage

// File: rtl/abs_diff_exact_ref.sv
// Combinational golden model: exact |A - B| of the two halves of stim, zero-extended.
module abs_diff_exact_ref
  import abs_diff_eval_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2
) (
  input  logic [N_IN-1:0]  stim,
  output logic [N_OUT-1:0] exact
);

  logic [N_IN/2-1:0] op_a;
  logic [N_IN/2-1:0] op_b;

  assign op_a  = stim[N_IN/2-1:0];
  assign op_b  = stim[N_IN-1:N_IN/2];
  assign exact = N_OUT'(exact_abs_diff(32'(op_a), 32'(op_b)));

endmodule

// File: rtl/abs_diff_err_monitor.sv
// Sweeps all input vectors through an approximate |A-B| netlist and accumulates error statistics.
module abs_diff_err_monitor
  import abs_diff_eval_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned ET    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_OUT-1:0]        dut_out,
  output logic [N_IN-1:0]         stim,
  output logic                    busy,
  output logic                    done,
  output logic [N_IN:0]           err_count,
  output logic [N_IN:0]           viol_count,
  output logic [N_OUT-1:0]        max_err,
  output logic [N_IN+N_OUT-1:0]   sum_err,
  output logic                    fail
);

  eval_state_e              state_q, state_d;
  logic [N_IN-1:0]          stim_q, stim_d;
  logic                     cap_valid_q, cap_valid_d;
  logic [N_OUT-1:0]         cap_exact_q, cap_exact_d;
  logic [N_OUT-1:0]         cap_dut_q, cap_dut_d;
  logic [N_IN:0]            err_cnt_q, err_cnt_d;
  logic [N_IN:0]            viol_cnt_q, viol_cnt_d;
  logic [N_OUT-1:0]         max_err_q, max_err_d;
  logic [N_IN+N_OUT-1:0]    sum_err_q, sum_err_d;

  logic [N_OUT-1:0]         exact;
  logic [N_OUT-1:0]         err;
  logic                     err_nz;
  logic                     err_viol;

  abs_diff_exact_ref #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_ref (
    .stim  (stim_q),
    .exact (exact)
  );

  assign err      = N_OUT'(abs_sub(32'(cap_exact_q), 32'(cap_dut_q)));
  assign err_nz   = (err != '0);
  assign err_viol = (32'(err) > ET);

  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    cap_valid_d = 1'b0;
    cap_exact_d = cap_exact_q;
    cap_dut_d   = cap_dut_q;
    err_cnt_d   = err_cnt_q;
    viol_cnt_d  = viol_cnt_q;
    max_err_d   = max_err_q;
    sum_err_d   = sum_err_q;

    // Capture register drains one edge behind the stimulus, so DRAIN picks up the last vector.
    if (cap_valid_q) begin
      err_cnt_d  = err_cnt_q + {{N_IN{1'b0}}, err_nz};
      viol_cnt_d = viol_cnt_q + {{N_IN{1'b0}}, err_viol};
      sum_err_d  = sum_err_q + {{N_IN{1'b0}}, err};
      if (err > max_err_q) max_err_d = err;
    end

    case (state_q)
      ST_IDLE: begin
        stim_d = '0;
        if (start) begin
          state_d    = ST_SWEEP;
          err_cnt_d  = '0;
          viol_cnt_d = '0;
          max_err_d  = '0;
          sum_err_d  = '0;
        end
      end
      ST_SWEEP: begin
        cap_exact_d = exact;
        cap_dut_d   = dut_out;
        cap_valid_d = 1'b1;
        if (stim_q == '1) begin
          state_d = ST_DRAIN;
          stim_d  = '0;
        end else begin
          stim_d  = stim_q + N_IN'(1);
        end
      end
      ST_DRAIN: begin
        stim_d  = '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        stim_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      stim_q      <= '0;
      cap_valid_q <= 1'b0;
      cap_exact_q <= '0;
      cap_dut_q   <= '0;
      err_cnt_q   <= '0;
      viol_cnt_q  <= '0;
      max_err_q   <= '0;
      sum_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      cap_valid_q <= cap_valid_d;
      cap_exact_q <= cap_exact_d;
      cap_dut_q   <= cap_dut_d;
      err_cnt_q   <= err_cnt_d;
      viol_cnt_q  <= viol_cnt_d;
      max_err_q   <= max_err_d;
      sum_err_q   <= sum_err_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign err_count  = err_cnt_q;
  assign viol_count = viol_cnt_q;
  assign max_err    = max_err_q;
  assign sum_err    = sum_err_q;
  assign fail       = (32'(max_err_q) > ET);

endmodule
